// File: rtl/sqrt_seq.sv
// sqrt_seq -- sequential fixed-point square root, one root bit per clock.
//
// The radicand is pre-shifted left by 2*FRAC_BITS. Then FRAC_BITS binary
// fraction bits of the root are produced by restoring digit-by-digit
// extraction. One operand is accepted on a valid/ready handshake. The
// result is held on a valid/ready handshake until the consumer accepts it.
// The fraction is also given exactly in decimal, as frac * 5^FRAC_BITS,
// in units of 10^-FRAC_BITS.
//
// Optional feature (macro SQRT_REM_EN):
//   When this macro is defined, two ports are added:
//     rem_o   -- final remainder X - root^2
//     exact_o -- set when rem_o is zero
//   Both are registered with the result. The latency does not change.
//
// Reset is synchronous and active-high (rst_i). It overrides every other
// input.
module sqrt_seq #(
   parameter int  IN_W      = 33,
   parameter int  FRAC_BITS = 5,
   localparam int XW        = ((IN_W + 2 * FRAC_BITS + 1) / 2) * 2,
   localparam int RW        = XW / 2,
   localparam int INT_W     = RW - FRAC_BITS,
   localparam int DEC_W     = $clog2(10 ** FRAC_BITS) + 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [IN_W-1:0]    data_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [INT_W-1:0]   result_o,
   output logic [FRAC_BITS-1:0] frac_o,
   output logic [DEC_W-1:0]   result_dec_o,
   output logic               busy_o
`ifdef SQRT_REM_EN
   ,
   output logic [RW:0]        rem_o,
   output logic               exact_o
`endif
);

   // Iteration counter width: it counts down from RW-1 to 0.
   localparam int CW = (RW > 1) ? $clog2(RW) : 1;

   // Exact decimal scale for the fraction:
   // frac / 2^F = frac * 5^F / 10^F.
   localparam logic [DEC_W-1:0] POW5_C = DEC_W'(5 ** FRAC_BITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Converts binary fraction bits into decimal units of 10^-FRAC_BITS.
   // The product always fits in DEC_W bits, because (2^F-1)*5^F < 10^F.
   function automatic logic [DEC_W-1:0] frac_to_dec(
      input logic [FRAC_BITS-1:0] f
   );
      return DEC_W'(f) * POW5_C;
   endfunction

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t              state_r;
   state_t              state_s;
   logic                ready_r;
   logic                valid_r;
   logic                busy_r;

   logic [XW-1:0]       x_r;
   logic [XW-1:0]       x_s;
   logic [RW-1:0]       root_r;
   logic [RW-1:0]       root_s;
   logic [RW+1:0]       rem_r;
   logic [RW+1:0]       rem_s;
   logic [CW-1:0]       cnt_r;
   logic [CW-1:0]       cnt_s;

   logic                load_s;
   logic                step_s;
   logic                finish_s;

   logic [XW-1:0]       x_load_s;
   logic [RW+3:0]       rem_shift_s;
   logic [RW+3:0]       trial_s;
   logic [RW+1:0]       diff_s;
   logic                ge_s;
   logic [RW+1:0]       rem_step_s;
   logic [RW-1:0]       root_step_s;

   logic [INT_W-1:0]     result_r;
   logic [FRAC_BITS-1:0] frac_r;
   logic [DEC_W-1:0]     dec_r;
`ifdef SQRT_REM_EN
   logic [RW:0]          rem_res_r;
   logic                 exact_r;
`endif

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------

   // Next-state logic, plus the load/step/finish strobes for the datapath.
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (valid_i) begin
               load_s  = 1'b1;
               state_s = CALC;
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            step_s = 1'b1;
            if (cnt_r == {CW{1'b0}}) begin
               finish_s = 1'b1;
               state_s  = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register. The handshake flags are registered and decoded from
   // the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         valid_r <= (state_s == DONE);
         busy_r  <= (state_s == CALC);
      end
   end

   // ------------------------------------------------------------------
   // Restoring square-root step
   // ------------------------------------------------------------------

   // Builds the pre-shifted radicand and computes one digit step.
   // The remainder is at most 2*root. Because of this bound, truncating
   // the difference and the shifted remainder to RW+2 bits loses nothing.
   always_comb begin
      x_load_s = {XW{1'b0}};
      x_load_s[2 * FRAC_BITS +: IN_W] = data_i;

      rem_shift_s = {rem_r, x_r[XW-1:XW-2]};
      trial_s     = {2'b00, root_r, 2'b01};
      ge_s        = (rem_shift_s >= trial_s);
      diff_s      = rem_shift_s[RW+1:0] - trial_s[RW+1:0];

      if (ge_s) begin
         rem_step_s  = diff_s;
         root_step_s = {root_r[RW-2:0], 1'b1};
      end else begin
         rem_step_s  = rem_shift_s[RW+1:0];
         root_step_s = {root_r[RW-2:0], 1'b0};
      end
   end

   // Next values for the working registers: load, iterate, or hold.
   always_comb begin
      x_s    = x_r;
      root_s = root_r;
      rem_s  = rem_r;
      cnt_s  = cnt_r;
      if (load_s) begin
         x_s    = x_load_s;
         root_s = {RW{1'b0}};
         rem_s  = {(RW + 2){1'b0}};
         cnt_s  = CW'(RW - 1);
      end else if (step_s) begin
         x_s    = {x_r[XW-3:0], 2'b00};
         root_s = root_step_s;
         rem_s  = rem_step_s;
         cnt_s  = cnt_r - CW'(1);
      end else begin
         x_s    = x_r;
         root_s = root_r;
         rem_s  = rem_r;
         cnt_s  = cnt_r;
      end
   end

   // Working registers for the radicand, partial root, remainder and
   // counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_r    <= {XW{1'b0}};
         root_r <= {RW{1'b0}};
         rem_r  <= {(RW + 2){1'b0}};
         cnt_r  <= {CW{1'b0}};
      end else begin
         x_r    <= x_s;
         root_r <= root_s;
         rem_r  <= rem_s;
         cnt_r  <= cnt_s;
      end
   end

   // ------------------------------------------------------------------
   // Result registers
   // ------------------------------------------------------------------

   // The result registers load only on the last iteration. They therefore
   // keep the last delivered result through IDLE and CALC.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_r  <= {INT_W{1'b0}};
         frac_r    <= {FRAC_BITS{1'b0}};
         dec_r     <= {DEC_W{1'b0}};
`ifdef SQRT_REM_EN
         rem_res_r <= {(RW + 1){1'b0}};
         exact_r   <= 1'b0;
`endif
      end else if (finish_s) begin
         result_r  <= root_step_s[RW-1:FRAC_BITS];
         frac_r    <= root_step_s[FRAC_BITS-1:0];
         dec_r     <= frac_to_dec(root_step_s[FRAC_BITS-1:0]);
`ifdef SQRT_REM_EN
         rem_res_r <= rem_step_s[RW:0];
         exact_r   <= (rem_step_s == {(RW + 2){1'b0}});
`endif
      end else begin
         result_r  <= result_r;
         frac_r    <= frac_r;
         dec_r     <= dec_r;
`ifdef SQRT_REM_EN
         rem_res_r <= rem_res_r;
         exact_r   <= exact_r;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ready_o      = ready_r;
   assign valid_o      = valid_r;
   assign busy_o       = busy_r;
   assign result_o     = result_r;
   assign frac_o       = frac_r;
   assign result_dec_o = dec_r;
`ifdef SQRT_REM_EN
   assign rem_o        = rem_res_r;
   assign exact_o      = exact_r;
`endif

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq -- self-checking bench for sqrt_seq.
//
// This bench uses the default parameters: IN_W=33, FRAC_BITS=5, which
// give RW=22. It applies the following stimulus:
//   - a table of directed vectors,
//   - random operands checked against a binary-search integer square root,
//   - a back-pressure sequence,
//   - a reset in the middle of an operation.
// The remainder ports are checked when SQRT_REM_EN is defined.
module tb_sqrt_seq;
   localparam int IN_W      = 33;
   localparam int FRAC_BITS = 5;
   localparam int RW        = 22;
   localparam int INT_W     = 17;
   localparam int DEC_W     = 18;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [IN_W-1:0]      data_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [INT_W-1:0]     result_o;
   logic [FRAC_BITS-1:0] frac_o;
   logic [DEC_W-1:0]     result_dec_o;
   logic                 busy_o;
`ifdef SQRT_REM_EN
   logic [RW:0]          rem_o;
   logic                 exact_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   sqrt_seq #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .data_i       (data_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .result_o     (result_o),
      .frac_o       (frac_o),
      .result_dec_o (result_dec_o),
      .busy_o       (busy_o)
`ifdef SQRT_REM_EN
      ,
      .rem_o        (rem_o),
      .exact_o      (exact_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IN_W-1:0] data;
      longint unsigned res;
      longint unsigned frac;
      longint unsigned dec;
      longint unsigned rem;
   } vec_t;

   vec_t vecs [7];

   task automatic check(
      input string           name,
      input longint unsigned act,
      input longint unsigned exp
   );
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [IN_W-1:0] rand33();
      logic [IN_W-1:0] d;
      d[31:0] = $urandom();
      d[32]   = 1'($urandom_range(0, 1));
      return d;
   endfunction

   // Reference: floor(sqrt(d * 4^FRAC_BITS)) by binary search.
   function automatic longint unsigned ref_root(input logic [IN_W-1:0] d);
      longint unsigned x;
      longint unsigned lo;
      longint unsigned hi;
      longint unsigned mid;
      x  = longint'(d) * (64'd1 << (2 * FRAC_BITS));
      lo = 64'd0;
      hi = 64'd1 << RW;
      while (hi - lo > 64'd1) begin
         mid = (lo + hi) / 64'd2;
         if (mid * mid <= x) lo = mid;
         else                hi = mid;
      end
      return lo;
   endfunction

   // Presents one operand and waits, with a bound, for valid_o.
   // Returns the number of edges between the accept edge and valid_o.
   task automatic run_op(input logic [IN_W-1:0] d, output int lat);
      @(negedge clk);
      check("accept_ready", longint'(ready_o), 64'd1);
      valid_i = 1'b1;
      data_i  = d;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      data_i  = rand33();
      check("calc_busy",  longint'(busy_o),  64'd1);
      check("calc_ready", longint'(ready_o), 64'd0);
      lat = 0;
      while (valid_o !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Accepts the result. The bench must then be back in IDLE with the
   // outputs held.
   task automatic release_result(input longint unsigned exp_res);
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("rel_valid", longint'(valid_o),  64'd0);
      check("rel_ready", longint'(ready_o),  64'd1);
      check("rel_busy",  longint'(busy_o),   64'd0);
      check("rel_hold",  longint'(result_o), exp_res);
   endtask

   task automatic check_model(input logic [IN_W-1:0] d);
      longint unsigned r;
      longint unsigned x;
      r = ref_root(d);
      x = longint'(d) * (64'd1 << (2 * FRAC_BITS));
      check("mdl_int",  longint'(result_o),     r >> FRAC_BITS);
      check("mdl_frac", longint'(frac_o),       r % 64'd32);
      check("mdl_dec",  longint'(result_dec_o), (r % 64'd32) * 64'd3125);
`ifdef SQRT_REM_EN
      check("mdl_rem",   longint'(rem_o),   x - r * r);
      check("mdl_exact", longint'(exact_o), (x == r * r) ? 64'd1 : 64'd0);
`endif
   endtask

   initial begin
      int              lat;
      logic [IN_W-1:0] d;

      vecs[0] = '{33'd2,          64'd1,     64'd13, 64'd40625, 64'd23};
      vecs[1] = '{33'd16,         64'd4,     64'd0,  64'd0,     64'd0};
      vecs[2] = '{33'h1_FFFF_FFFF, 64'd92681, 64'd28, 64'd87500, 64'd4748784};
      vecs[3] = '{33'd0,          64'd0,     64'd0,  64'd0,     64'd0};
      vecs[4] = '{33'd3,          64'd1,     64'd23, 64'd71875, 64'd47};
      vecs[5] = '{33'd1,          64'd1,     64'd0,  64'd0,     64'd0};
      vecs[6] = '{33'd1000000,    64'd1000,  64'd0,  64'd0,     64'd0};

      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      data_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  longint'(ready_o),      64'd1);
      check("rst_valid",  longint'(valid_o),      64'd0);
      check("rst_busy",   longint'(busy_o),       64'd0);
      check("rst_result", longint'(result_o),     64'd0);
      check("rst_frac",   longint'(frac_o),       64'd0);
      check("rst_dec",    longint'(result_dec_o), 64'd0);
      rst_i = 1'b0;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].data, lat);
         check("vec_latency", longint'(lat),          64'd22);
         check("vec_int",     longint'(result_o),     vecs[i].res);
         check("vec_frac",    longint'(frac_o),       vecs[i].frac);
         check("vec_dec",     longint'(result_dec_o), vecs[i].dec);
`ifdef SQRT_REM_EN
         check("vec_rem",   longint'(rem_o),   vecs[i].rem);
         check("vec_exact", longint'(exact_o),
               (vecs[i].rem == 64'd0) ? 64'd1 : 64'd0);
`endif
         release_result(vecs[i].res);
      end

      // Random operands against the model
      for (int i = 0; i < 20; i++) begin
         d = rand33();
         run_op(d, lat);
         check("rnd_latency", longint'(lat), 64'd22);
         check_model(d);
         release_result(ref_root(d) >> FRAC_BITS);
      end

      // Back-pressure in DONE. Valid operands arrive here and must be
      // ignored.
      ready_i = 1'b0;
      run_op(33'd16, lat);
      check("bp_latency", longint'(lat), 64'd22);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         valid_i = 1'b1;
         data_i  = rand33();
         @(posedge clk);
         #1;
         check("bp_valid",  longint'(valid_o),  64'd1);
         check("bp_ready",  longint'(ready_o),  64'd0);
         check("bp_busy",   longint'(busy_o),   64'd0);
         check("bp_int",    longint'(result_o), 64'd4);
         check("bp_frac",   longint'(frac_o),   64'd0);
      end
      @(negedge clk);
      ready_i = 1'b1;
      data_i  = 33'd2;
      @(posedge clk);
      #1;
      check("bp_hs_valid", longint'(valid_o), 64'd0);
      check("bp_hs_ready", longint'(ready_o), 64'd1);
      check("bp_hs_busy",  longint'(busy_o),  64'd0);
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      check("bp_idle_busy", longint'(busy_o),   64'd0);
      check("bp_idle_hold", longint'(result_o), 64'd4);

      // Reset at CALC cycle 10
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = 33'h1_FFFF_FFFF;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid_busy", longint'(busy_o), 64'd1);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("mid_ready",  longint'(ready_o),      64'd1);
      check("mid_valid",  longint'(valid_o),      64'd0);
      check("mid_busy0",  longint'(busy_o),       64'd0);
      check("mid_result", longint'(result_o),     64'd0);
      check("mid_frac",   longint'(frac_o),       64'd0);
      check("mid_dec",    longint'(result_dec_o), 64'd0);
      rst_i = 1'b0;
      run_op(33'd2, lat);
      check("post_latency", longint'(lat),          64'd22);
      check("post_int",     longint'(result_o),     64'd1);
      check("post_frac",    longint'(frac_o),       64'd13);
      check("post_dec",     longint'(result_dec_o), 64'd40625);
`ifdef SQRT_REM_EN
      check("post_rem", longint'(rem_o), 64'd23);
`endif
      release_result(64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
